imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pkg.sv | 24 ++
 rtl/imm_ext_core.sv | 58 +++++
 rtl/imm_ext_pipe.sv | 94 +++++++++
 tb/tb_imm_ext_pipe.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared immediate-extension mode encodings and helpers
// Contents: imm_mode_e (3-bit extension mode), mode_is_legal() predicate.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        MODE_SEXT  = 3'b000,
        MODE_ZEXT  = 3'b001,
        MODE_LUI   = 3'b010,
        MODE_BR    = 3'b011,
        MODE_J     = 3'b100,
        MODE_SHAMT = 3'b101,
        MODE_RSV6  = 3'b110,
        MODE_RSV7  = 3'b111
    } imm_mode_e;

    localparam int unsigned ERR_CNT_W   = 8;
    localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

    // Encodings 110 and 111 are reserved for future decode extensions.
    function automatic logic mode_is_legal(input logic [2:0] m);
        return (m != MODE_RSV6) && (m != MODE_RSV7);
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate extension function
// Ports:
//   imm    [JIMM_W-1:0]  raw instruction immediate field
//   mode   [2:0]         extension mode select
//   pc     [DATA_W-1:0]  PC of the instruction being decoded
//   result [DATA_W-1:0]  extended immediate / computed target
//   legal                mode is not a reserved encoding
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIMM_W = 26
) (
    input  logic [JIMM_W-1:0] imm,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] result,
    output logic              legal
);

    logic [IMM_W-1:0]  i16;
    logic [DATA_W-1:0] sext_v;
    logic [DATA_W-1:0] zext_v;
    logic [DATA_W-1:0] lui_v;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] br_v;
    logic [DATA_W-1:0] j_v;
    logic [DATA_W-1:0] shamt_v;
    imm_mode_e         mode_e;

    assign i16     = imm[IMM_W-1:0];
    assign sext_v  = {{(DATA_W-IMM_W){i16[IMM_W-1]}}, i16};
    assign zext_v  = DATA_W'(i16);
    assign lui_v   = DATA_W'({i16, {(32-IMM_W){1'b0}}});
    assign pc4     = pc + DATA_W'(4);
    // Branch target wraps modulo 2^DATA_W; no overflow is reported.
    assign br_v    = pc4 + (sext_v << 2);
    // Jump keeps the 256 MB region of the sequential PC.
    assign j_v     = DATA_W'({pc4[31:JIMM_W+2], imm, 2'b00});
    assign shamt_v = DATA_W'(imm[10:6]);
    assign mode_e  = imm_mode_e'(mode);

    always_comb begin
        result = '0;
        legal  = 1'b1;
        case (mode_e)
            MODE_SEXT:  result = sext_v;
            MODE_ZEXT:  result = zext_v;
            MODE_LUI:   result = lui_v;
            MODE_BR:    result = br_v;
            MODE_J:     result = j_v;
            MODE_SHAMT: result = shamt_v;
            default:    legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - one-stage registered immediate extender with error counting
// Ports:
//   clk, reset (async active-low)
//   imm, mode, pc, valid_in   decode-stage fields
//   stall, flush              pipeline control (flush has priority)
//   imm_out, valid_out        registered result
//   mode_err                  one-cycle pulse per accepted reserved mode
//   err_cnt                   saturating reserved-mode event count
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIMM_W = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JIMM_W-1:0] imm,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] pc,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] imm_out,
    output logic              valid_out,
    output logic              mode_err,
    output logic [7:0]        err_cnt
);

    logic [DATA_W-1:0] core_result;
    logic              core_legal;

    logic [DATA_W-1:0] imm_q,   imm_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;
    logic [7:0]        cnt_q,   cnt_d;

    imm_ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .JIMM_W (JIMM_W)
    ) u_core (
        .imm    (imm),
        .mode   (mode),
        .pc     (pc),
        .result (core_result),
        .legal  (core_legal)
    );

    always_comb begin
        imm_d   = imm_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (flush) begin
            imm_d   = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            // Hold result; the error pulse still drops so it never stretches.
        end else if (valid_in && core_legal) begin
            imm_d   = core_result;
            valid_d = 1'b1;
        end else if (valid_in) begin
            // Reserved mode: keep the last good value, mark it invalid.
            valid_d = 1'b0;
            err_d   = 1'b1;
            if (cnt_q != ERR_CNT_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imm_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            imm_q   <= imm_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imm_out   = imm_q;
    assign valid_out = valid_q;
    assign mode_err  = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - self-checking bench for imm_ext_pipe
module tb_imm_ext_pipe;

    logic        clk;
    logic        reset;
    logic [25:0] imm;
    logic [2:0]  mode;
    logic [31:0] pc;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic [31:0] imm_out;
    logic        valid_out;
    logic        mode_err;
    logic [7:0]  err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_imm;
    logic        exp_valid;
    logic        exp_err;
    int          exp_cnt;

    imm_ext_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .imm       (imm),
        .mode      (mode),
        .pc        (pc),
        .valid_in  (valid_in),
        .stall     (stall),
        .flush     (flush),
        .imm_out   (imm_out),
        .valid_out (valid_out),
        .mode_err  (mode_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the extension rules written as plain unsigned arithmetic.
    function automatic logic [31:0] ref_ext(input int unsigned m, input int unsigned f,
                                            input int unsigned p);
        int unsigned i16;
        int unsigned sx;
        i16 = f % 65536;
        sx  = (i16 >= 32768) ? i16 - 32'd65536 : i16;
        case (m)
            0: return sx;
            1: return i16;
            2: return i16 * 65536;
            3: return p + 4 + sx * 4;
            4: return ((p + 4) / 32'h1000_0000) * 32'h1000_0000 + (f % 32'h0400_0000) * 4;
            5: return (f / 64) % 32;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".imm_out"},   imm_out,          exp_imm);
        chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, exp_valid});
        chk({tag, ".mode_err"},  {31'd0, mode_err},  {31'd0, exp_err});
        chk({tag, ".err_cnt"},   {24'd0, err_cnt},   32'(exp_cnt));
    endtask

    task automatic step(input string tag, input logic f, input logic s, input logic v,
                        input logic [2:0] m, input logic [25:0] im, input logic [31:0] p);
        @(negedge clk);
        flush = f; stall = s; valid_in = v; mode = m; imm = im; pc = p;
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        if (f) begin
            exp_imm = 32'd0; exp_valid = 1'b0;
        end else if (s) begin
        end else if (v && m < 6) begin
            exp_imm = ref_ext(m, im, p); exp_valid = 1'b1;
        end else if (v) begin
            exp_valid = 1'b0; exp_err = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
        end else begin
            exp_valid = 1'b0;
        end
        chk_all(tag);
    endtask

    initial begin
        reset = 1'b1; flush = 0; stall = 0; valid_in = 0; mode = 0; imm = 0; pc = 0;
        exp_imm = 0; exp_valid = 0; exp_err = 0; exp_cnt = 0;
        #1 reset = 1'b0;
        #1 chk_all("reset");
        @(negedge clk) reset = 1'b1;

        step("sext",  0, 0, 1, 3'd0, 26'h8001, 32'h0);
        chk("sext.lit", imm_out, 32'hFFFF8001);
        step("zext",  0, 0, 1, 3'd1, 26'h8001, 32'h0);
        chk("zext.lit", imm_out, 32'h00008001);
        step("lui",   0, 0, 1, 3'd2, 26'h8001, 32'h0);
        chk("lui.lit", imm_out, 32'h80010000);
        step("shamt", 0, 0, 1, 3'd5, 26'h8001, 32'h0);
        chk("shamt.lit", imm_out, 32'h0);
        step("shamt2", 0, 0, 1, 3'd5, 26'h07C0, 32'h0);
        step("br",    0, 0, 1, 3'd3, 26'hFFFF, 32'h00003000);
        chk("br.lit", imm_out, 32'h00003000);
        step("br.wrap", 0, 0, 1, 3'd3, 26'h7FFF, 32'hFFFFFFF0);
        step("j",     0, 0, 1, 3'd4, 26'h0000C00, 32'h40003000);
        chk("j.lit", imm_out, 32'h40003000);
        step("j.top", 0, 0, 1, 3'd4, 26'h3FFFFFF, 32'hEFFFFFFC);

        step("sext2", 0, 0, 1, 3'd0, 26'h1234, 32'h0);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 1, 3'd1, 26'hFFFF, 32'h0);
        chk("stall.lit", imm_out, 32'h00001234);
        step("stall+flush", 1, 1, 1, 3'd0, 26'h5555, 32'h0);
        chk("flush.lit", imm_out, 32'h0);

        step("lui1234", 0, 0, 1, 3'd2, 26'h1234, 32'h0);
        step("rsv6",    0, 0, 1, 3'd6, 26'h1111, 32'h0);
        chk("rsv.lit", imm_out, 32'h12340000);
        chk("rsv.cnt", {24'd0, err_cnt}, 32'd1);
        step("rsv.idle", 0, 0, 0, 3'd0, 26'h0, 32'h0);
        step("rsv.stall", 0, 1, 1, 3'd7, 26'h0, 32'h0);

        for (int i = 0; i < 300; i++)
            step("sat", 0, 0, 1, 3'($urandom_range(6, 7)), 26'($urandom), 32'h0);
        chk("sat.lit", {24'd0, err_cnt}, 32'd255);
        step("sat.hold", 0, 0, 1, 3'd7, 26'h0, 32'h0);

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 26'($urandom), $urandom);

        step("pre_arst", 0, 0, 1, 3'd1, 26'hABCD, 32'h0);
        #2;
        reset = 1'b0; flush = 0; stall = 0; valid_in = 0;
        #1;
        exp_imm = 0; exp_valid = 0; exp_err = 0; exp_cnt = 0;
        chk_all("arst");
        @(negedge clk) reset = 1'b1;
        step("post_arst", 0, 0, 1, 3'd2, 26'hBEEF, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
